// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner of the shared 8-input, 16-bit datapath mux.
// Grants one requester at a time for a multi-beat transfer and drives the
// registered mux select/enable. A grant ends on the owner's last beat, when
// the owner drops its request, or (optional) when a watchdog beat limit is hit.
//
// Optional feature macro: ARB_WATCHDOG_EN
//   defined   -> MAX_BEATS parameter exists; transfers are cut off after
//                MAX_BEATS accepted beats without a last flag (timeout pulse)
//   undefined -> no watchdog, timeout is constant 0, transfers are unbounded
module rr_mux_arbiter #(
  parameter int BEAT_W = 8
`ifdef ARB_WATCHDOG_EN
  , parameter int MAX_BEATS = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        req,
  input  logic [7:0]        last,
  input  logic              out_ready,
  output logic [2:0]        sel,
  output logic              en,
  output logic [7:0]        gnt,
  output logic              done,
  output logic              abort,
  output logic              timeout,
  output logic [BEAT_W-1:0] beat_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

  state_t            state;
  logic [2:0]        ptr;

  logic              accept;
  logic              last_sel;
  logic              fin;
  logic              drop;
  logic              wd_hit;
  logic [BEAT_W-1:0] beat_next;
  logic [2:0]        pick;

  // First requester at or after p, wrapping 7 -> 0. Scanning from the far
  // end down lets the nearest hit overwrite earlier ones without a break.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] win;
    win = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  // Beat counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [BEAT_W-1:0] sat_inc(input logic [BEAT_W-1:0] c);
    return (c == BEAT_MAX) ? c : c + 1'b1;
  endfunction

  // Release conditions of the current owner, evaluated every BUSY cycle.
  always_comb begin
    accept    = out_ready;
    last_sel  = last[sel];
    fin       = accept & last_sel;
    drop      = ~req[sel];
    beat_next = sat_inc(beat_cnt);
    pick      = rr_pick(req, ptr);
  end

`ifdef ARB_WATCHDOG_EN
  localparam logic [BEAT_W-1:0] WD_LIMIT = BEAT_W'(MAX_BEATS);

  // Watchdog fires on the accepted non-last beat that reaches the limit.
  always_comb begin
    wd_hit = accept & ~last_sel & (beat_next == WD_LIMIT);
  end
`else
  // No watchdog: the timeout path collapses to a constant.
  always_comb begin
    wd_hit = 1'b0;
  end
`endif

  // Arbiter FSM: all mux control and status outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      sel      <= 3'd0;
      en       <= 1'b0;
      gnt      <= 8'h00;
      done     <= 1'b0;
      abort    <= 1'b0;
      timeout  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      done    <= 1'b0;
      abort   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 8'h00) begin
            state    <= BUSY;
            sel      <= pick;
            en       <= 1'b1;
            gnt      <= 8'h01 << pick;
            beat_cnt <= '0;
          end
        end
        BUSY: begin
          if (accept) beat_cnt <= beat_next;
          // Completion beats abort, abort beats watchdog.
          if (fin || drop || wd_hit) begin
            state <= IDLE;
            en    <= 1'b0;
            gnt   <= 8'h00;
            ptr   <= sel + 3'd1;
            if (fin)       done    <= 1'b1;
            else if (drop) abort   <= 1'b1;
            else           timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
